pipe_intr_ifid_skid_fpu: RTL
============================

// Module: pipe_intr_ifid_skid_fpu
// PURPOSE
//  IF/ID pipeline boundary for the interrupt-capable FPU pipeline. Registers pc, pc4 and inst
//  from the IF stage and presents them to the ID stage.
//  A 2-entry skid buffer decouples IF from ID back-pressure (FPU/load-use stalls).
//  Supports exception/redirect flush.
//  Tags each instruction with a branch-delay-slot flag for EPC selection in ID.
// PARAMETERS
//  DW      32             datapath width of pc, pc4 and inst
//  NOP     32'h0000_0000  instruction word driven on d_inst when d_valid=0
// PORTS
//  clk        in   1   rising-edge clock
//  clrn       in   1   asynchronous active-low reset
//  f_pc       in   DW  pc of fetched instruction
//  f_pc4      in   DW  pc+4 of fetched instruction
//  f_inst     in   DW  fetched instruction word
//  f_valid    in   1   IF presents an instruction this cycle
//  f_ready    out  1   buffer can accept; IF advances pc only when f_valid&f_ready
//  d_pc       out  DW  pc of instruction held for ID
//  d_pc4      out  DW  pc+4 of instruction held for ID
//  d_inst     out  DW  instruction for ID (NOP when invalid)
//  d_valid    out  1   ID-side entry is valid
//  d_ready    in   1   ID consumes the entry this cycle (0 = stall)
//  d_isbd     out  1   held instruction sits in a branch/jump delay slot
//  d_isbr     in   1   instruction in ID is a branch/jump (decoded in ID)
//  cancel     in   1   flush: exception/interrupt redirect, drop all held entries
// BEHAVIOUR
//  - Reset (clrn=0, async): both entries invalid; d_pc=d_pc4=0; d_inst=NOP; d_valid=0;
//    d_isbd=0; bd_pending=0; f_ready=1.
//  - Storage: head entry (drives d_*) and skid entry. Each entry holds {pc, pc4, inst, valid}.
//  - f_ready = ~skid.valid. This is a registered signal; it has no combinational path
//    from d_ready.
//  - Transfers: accept = f_valid&f_ready; consume = d_valid&d_ready.
//  - Per clock, with no cancel:
//    - head empty, accept: load head.
//    - head full, consume, skid empty, accept: load head.
//    - head full, consume, skid empty, no accept: head invalid.
//    - head full, consume, skid full: skid->head, skid invalid. f_ready=0 here, so no accept.
//    - head full, no consume, accept: load skid.
//  - Latency: 1 cycle from accept to d_valid. Full throughput when d_ready=1.
//  - cancel=1 (sync): head and skid invalidated, bd_pending cleared, any same-cycle accept
//    dropped (cancel wins). Next cycle: d_valid=0, d_inst=NOP, f_ready=1.
//  - Delay slot: bd_pending is set on consume with d_isbr=1.
//    - The next entry loaded into head while bd_pending=1 gets isbd=1; bd_pending clears
//      on that load.
//    - Set and clear in the same cycle: set wins. The consumed entry's successor takes
//      the flag.
//    - cancel overrides both.
//  - d_isbd = head.isbd & head.valid. Skid entries take isbd when they move to head.
//  - Invalid head: d_pc/d_pc4 hold their last value; d_inst forced to NOP.
//  - Reset mid-operation: all state discarded immediately. No partial entries survive.
//  - Ordering: strict FIFO. An instruction is never duplicated or reordered.
// TESTING
//  - Reset: clrn low mid-stream -> d_valid=0, d_inst=0, f_ready=1 that cycle;
//    after clrn=1 with f_valid=0 outputs stay idle.
//  - Streaming: f_valid=1, d_ready=1, pc 0x0,0x4,0x8 -> d_pc 0x0,0x4,0x8 one cycle later,
//    d_valid=1 each cycle, f_ready=1 throughout.
//  - Stall/skid: d_ready=0 for 3 cycles while IF offers 0x10,0x14,0x18 -> head=0x10,
//    skid=0x14, f_ready=0. 0x18 is held by IF. On d_ready=1: 0x10,0x14,0x18 in order,
//    no loss or duplication.
//  - Cancel: skid full, cancel=1 with f_valid=1 (pc 0x20) -> next cycle d_valid=0,
//    d_inst=0, f_ready=1. pc 0x08 (EXC_BASE) fetched after is the next d_pc.
//  - Delay slot: d_isbr=1 consumed at pc 0x40 -> pc 0x44 appears with d_isbd=1,
//    pc 0x48 with d_isbd=0. Repeat with a 2-cycle stall between: the flag still lands on 0x44.
//  - Cancel vs delay slot: branch consumed then cancel -> bd_pending cleared;
//    first post-cancel instruction has d_isbd=0.

Source files
------------

// File: rtl/pipe_intr_ifid_skid_fpu_if.sv
// IF/ID boundary bundle: fetch-side and decode-side handshakes plus flush.
// slave = the skid buffer, master = the surrounding pipeline.
interface pipe_intr_ifid_skid_fpu_if #(
  parameter int DW = 32
);
  logic [DW-1:0] f_pc;
  logic [DW-1:0] f_pc4;
  logic [DW-1:0] f_inst;
  logic          f_valid;
  logic          f_ready;
  logic [DW-1:0] d_pc;
  logic [DW-1:0] d_pc4;
  logic [DW-1:0] d_inst;
  logic          d_valid;
  logic          d_ready;
  logic          d_isbd;
  logic          d_isbr;
  logic          cancel;

  modport slave (
    input  f_pc, f_pc4, f_inst, f_valid,
    input  d_ready, d_isbr, cancel,
    output f_ready,
    output d_pc, d_pc4, d_inst, d_valid, d_isbd
  );

  modport master (
    output f_pc, f_pc4, f_inst, f_valid,
    output d_ready, d_isbr, cancel,
    input  f_ready,
    input  d_pc, d_pc4, d_inst, d_valid, d_isbd
  );
endinterface

// File: rtl/pipe_intr_ifid_skid_fpu.sv
// IF/ID register with a 2-entry skid buffer, flush and
// branch-delay-slot tagging for EPC selection in ID.
module pipe_intr_ifid_skid_fpu #(
  parameter int            DW  = 32,
  parameter logic [DW-1:0] NOP = '0
) (
  input logic                      clk,
  input logic                      clrn,
  pipe_intr_ifid_skid_fpu_if.slave bus
);

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] pc4;
    logic [DW-1:0] inst;
  } ent_t;

  ent_t r_head;
  ent_t r_skid;
  logic r_hv;
  logic r_sv;
  logic r_hbd;
  logic r_bd;

  ent_t w_fent;
  logic w_acc;
  logic w_con;
  logic w_bd;
  logic w_ld_f;
  logic w_s2h;
  logic w_drain;
  logic w_ld_s;
  logic w_hload;

  assign w_fent  = {bus.f_pc, bus.f_pc4, bus.f_inst};
  assign w_acc   = bus.f_valid & ~r_sv;
  assign w_con   = r_hv & bus.d_ready;

  // successor of a consumed branch takes the flag in the same cycle
  assign w_bd    = r_bd | (w_con & bus.d_isbr);

  assign w_ld_f  = ~bus.cancel & w_acc
                 & (~r_hv | (w_con & ~r_sv));
  assign w_s2h   = ~bus.cancel & w_con & r_sv;
  assign w_drain = ~bus.cancel & w_con & ~r_sv & ~w_acc;
  assign w_ld_s  = ~bus.cancel & r_hv & ~w_con & w_acc;
  assign w_hload = w_ld_f | w_s2h;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_head <= '0;
      r_skid <= '0;
      r_hv   <= 1'b0;
      r_sv   <= 1'b0;
      r_hbd  <= 1'b0;
      r_bd   <= 1'b0;
    end else begin
      unique case (1'b1)
        bus.cancel: begin
          r_hv <= 1'b0;
          r_sv <= 1'b0;
        end
        w_ld_f: begin
          r_head <= w_fent;
          r_hv   <= 1'b1;
        end
        w_s2h: begin
          r_head <= r_skid;
          r_sv   <= 1'b0;
        end
        w_drain: r_hv <= 1'b0;
        w_ld_s: begin
          r_skid <= w_fent;
          r_sv   <= 1'b1;
        end
        default: ;
      endcase
      if (w_hload) r_hbd <= w_bd;
      r_bd <= ~bus.cancel & ~w_hload & w_bd;
    end
  end

  assign bus.f_ready = ~r_sv;
  assign bus.d_pc    = r_head.pc;
  assign bus.d_pc4   = r_head.pc4;
  assign bus.d_inst  = r_hv ? r_head.inst : NOP;
  assign bus.d_valid = r_hv;
  assign bus.d_isbd  = r_hbd & r_hv;

endmodule
